yd_dbus_resp: RTL
=================

YD_DBUS_RESP -- requirements
Module: YD_dbus_resp

Interface
REQ-001 SHALL have parameter DW, default 16, data width.
REQ-002 SHALL have parameter AW, default 16, address width.
REQ-003 SHALL have parameter RAM_AW, default 10, RAM word-address width (depth 2^RAM_AW).
REQ-004 SHALL have parameter PRE, default 4, timer prescale divisor, legal range 1..65535.
REQ-005 SHALL have ports:
  clk  input  1  single clock, all logic on rising edge
  rst  input  1  synchronous reset, active high
  d_din  input  DW  write data from core
  d_addr  input  AW  word address from core
  d_we  input  1  write enable, active high
  d_dout  output  DW  read data to core
  gpio_i  input  16  asynchronous external inputs
  gpio_o  output  16  GPIO output register
  tmr_irq  output  1  timer interrupt, level, active high

Function
REQ-006 Address map SHALL be: 0x0000..2^RAM_AW-1 RAM; 0xFF00 GPIO_OUT (RW); 0xFF01 GPIO_IN (RO); 0xFF02 TMR_CNT (RW); 0xFF03 TMR_CMP (RW); 0xFF04 TMR_CTRL (RW, bit0 EN, bit1 AUTOCLR, bit2 IRQEN, other bits read 0); 0xFF05 TMR_STAT (bit0 MATCH, write-1-to-clear).
REQ-007 All other addresses SHALL read 0; writes to them SHALL be ignored.
REQ-008 Writes SHALL take effect on the rising edge where d_we=1, with no handshake and no stall.
REQ-009 Reads SHALL be unconditional: d_dout SHALL be registered, showing the value at the d_addr sampled on edge N, valid after edge N, held until the next edge.
REQ-010 Read and write to the same address on one edge SHALL return the old value (read-first).
REQ-011 RAM SHALL be single-port synchronous, DW wide, with contents not reset.
REQ-012 gpio_i SHALL pass through a 2-flop synchronizer; a GPIO_IN read returns the synchronized value (2-cycle input latency, 3 cycles to d_dout).
REQ-013 Prescaler SHALL count 0..PRE-1 while EN=1 and issue one tick at PRE-1, then return to 0; when EN=0 it SHALL hold at 0.
REQ-014 On a tick: if TMR_CNT==TMR_CMP, MATCH SHALL set, and TMR_CNT SHALL become 0 if AUTOCLR=1, else TMR_CNT+1; otherwise TMR_CNT SHALL increment modulo 2^16 (0xFFFF wraps to 0x0000).
REQ-015 A core write to TMR_CNT on a tick edge SHALL override the increment.
REQ-016 A MATCH set and a W1C clear on the same edge SHALL leave MATCH=1.
REQ-017 Writing TMR_CTRL with EN=0 SHALL also clear the prescaler, so the first tick after re-enable lands PRE cycles later.
REQ-018 tmr_irq SHALL equal MATCH & IRQEN, driven from registers with no combinational path from inputs.
REQ-019 gpio_o SHALL reflect GPIO_OUT directly.

Reset
REQ-020 On rst=1 at a rising edge, the block SHALL set d_dout=0, GPIO_OUT=0, TMR_CNT=0, TMR_CMP=0xFFFF, TMR_CTRL=0, MATCH=0, prescaler=0 and synchronizer flops=0; RAM keeps its contents.
REQ-021 rst SHALL take priority over any write or tick in the same cycle; reset mid-count SHALL abandon the count.

Verification
REQ-022 RAM: write 0xBEEF @0x0003, then read 0x0003 -> d_dout=0xBEEF one cycle after the read address; same-edge write 0x1234/read @0x0003 -> 0xBEEF, next read -> 0x1234.
REQ-023 Unmapped/GPIO: write 0x5555 @0x8000, read back -> 0x0000; write 0x00A5 @0xFF00 -> gpio_o=0x00A5; gpio_i=0x1234 -> GPIO_IN read returns 0x1234 at most 3 cycles later.
REQ-024 Timer with PRE=4: CMP=3, CTRL=0x7 -> MATCH set and tmr_irq=1 on the 16th cycle after the enable write, CNT=0; write 0x1 @0xFF05 -> tmr_irq=0 next cycle.
REQ-025 Wrap and collisions: CTRL=0x1, CNT=0xFFFF, CMP=0x0005 -> CNT=0x0000 after the tick and MATCH=0; a CNT write of 0x0100 on a tick edge -> CNT=0x0100; a W1C on the match edge -> MATCH=1.
REQ-026 Reset: assert rst during a running count (CNT=0x0002) -> the next cycle shows all registers at reset values, tmr_irq=0, d_dout=0, and the RAM word at 0x0003 still reads 0x1234.

Source files
------------

// File: rtl/yd_dbus_resp.sv
// yd_dbus_resp -- data-bus responder for a small core.
//
// Decodes the core's data bus into a word RAM and a block of memory-mapped
// peripheral registers: a GPIO output latch, a synchronized GPIO input and a
// 16-bit prescaled timer with compare match and a level interrupt.
//
// Ports:
//   clk      rising-edge clock for all logic
//   rst      synchronous reset, active high
//   d_din    write data from core (DW)
//   d_addr   word address from core (AW)
//   d_we     write enable, active high
//   d_dout   registered read data to core (DW)
//   gpio_i   asynchronous external inputs (16)
//   gpio_o   GPIO output register (16)
//   tmr_irq  timer interrupt, level, active high
//
// Address map:
//   0x0000 .. 2^RAM_AW-1  RAM
//   0xFF00 GPIO_OUT (RW)   0xFF01 GPIO_IN (RO)
//   0xFF02 TMR_CNT  (RW)   0xFF03 TMR_CMP (RW)
//   0xFF04 TMR_CTRL (RW: bit0 EN, bit1 AUTOCLR, bit2 IRQEN)
//   0xFF05 TMR_STAT (bit0 MATCH, write 1 to clear)
// Everything else reads 0 and ignores writes.

module yd_dbus_resp #(
  parameter int DW     = 16,
  parameter int AW     = 16,
  parameter int RAM_AW = 10,
  parameter int PRE    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] d_din,
  input  logic [AW-1:0] d_addr,
  input  logic          d_we,
  output logic [DW-1:0] d_dout,
  input  logic [15:0]   gpio_i,
  output logic [15:0]   gpio_o,
  output logic          tmr_irq
);

  localparam logic [AW-1:0] A_GPIO_OUT = AW'(16'hFF00);
  localparam logic [AW-1:0] A_GPIO_IN  = AW'(16'hFF01);
  localparam logic [AW-1:0] A_TMR_CNT  = AW'(16'hFF02);
  localparam logic [AW-1:0] A_TMR_CMP  = AW'(16'hFF03);
  localparam logic [AW-1:0] A_TMR_CTRL = AW'(16'hFF04);
  localparam logic [AW-1:0] A_TMR_STAT = AW'(16'hFF05);
  localparam logic [15:0]   PSC_LAST   = 16'(PRE - 1);

  // Peripheral registers are 16 bits; widen onto the DW-wide read bus.
  function automatic logic [DW-1:0] to_dw(input logic [15:0] v);
    return DW'(v);
  endfunction

  logic [DW-1:0]     mem [0:(1<<RAM_AW)-1];
  logic [15:0]       gpio_out;
  logic [15:0]       gpio_sync_p0;
  logic [15:0]       gpio_sync_p1;
  logic [15:0]       tmr_cnt;
  logic [15:0]       tmr_cmp;
  logic [2:0]        tmr_ctrl;
  logic              tmr_match;
  logic [15:0]       psc;

  logic              ram_hit;
  logic [RAM_AW-1:0] ram_idx;
  logic [15:0]       wd16;
  logic              tick;
  logic              wr_gpio, wr_cnt, wr_cmp, wr_ctrl, wr_stat;
  logic [DW-1:0]     rd_val;

  assign ram_hit = ((d_addr >> RAM_AW) == '0);
  assign ram_idx = d_addr[RAM_AW-1:0];
  assign wd16    = 16'(d_din);

  assign wr_gpio = d_we && (d_addr == A_GPIO_OUT);
  assign wr_cnt  = d_we && (d_addr == A_TMR_CNT);
  assign wr_cmp  = d_we && (d_addr == A_TMR_CMP);
  assign wr_ctrl = d_we && (d_addr == A_TMR_CTRL);
  assign wr_stat = d_we && (d_addr == A_TMR_STAT);

  // One tick per PRE enabled cycles, on the last prescaler count.
  assign tick = tmr_ctrl[0] && (psc == PSC_LAST);

  // Read mux uses pre-edge state, which gives read-first behaviour.
  always_comb begin
    rd_val = '0;
    if (ram_hit) begin
      rd_val = mem[ram_idx];
    end else begin
      case (d_addr)
        A_GPIO_OUT: rd_val = to_dw(gpio_out);
        A_GPIO_IN:  rd_val = to_dw(gpio_sync_p1);
        A_TMR_CNT:  rd_val = to_dw(tmr_cnt);
        A_TMR_CMP:  rd_val = to_dw(tmr_cmp);
        A_TMR_CTRL: rd_val = to_dw({13'd0, tmr_ctrl});
        A_TMR_STAT: rd_val = to_dw({15'd0, tmr_match});
        default:    rd_val = '0;
      endcase
    end
  end

  // RAM array: never reset; a reset cycle also blocks writes.
  always_ff @(posedge clk) begin
    if (!rst && d_we && ram_hit) begin
      mem[ram_idx] <= d_din;
    end
  end

  // Stage p0/p1: two-flop synchronizer on the external inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      gpio_sync_p0 <= '0;
      gpio_sync_p1 <= '0;
    end else begin
      gpio_sync_p0 <= gpio_i;
      gpio_sync_p1 <= gpio_sync_p0;
    end
  end

  // Register file, timer and read-data register.
  always_ff @(posedge clk) begin
    if (rst) begin
      d_dout    <= '0;
      gpio_out  <= '0;
      tmr_cnt   <= '0;
      tmr_cmp   <= 16'hFFFF;
      tmr_ctrl  <= '0;
      tmr_match <= 1'b0;
      psc       <= '0;
    end else begin
      d_dout <= rd_val;

      if (wr_gpio) gpio_out <= wd16;
      if (wr_cmp)  tmr_cmp  <= wd16;
      if (wr_ctrl) tmr_ctrl <= wd16[2:0];

      if (!tmr_ctrl[0] || tick) psc <= '0;
      else                      psc <= psc + 16'd1;
      // Disabling via a CTRL write restarts the prescale period.
      if (wr_ctrl && !wd16[0]) psc <= '0;

      // Clear first so a same-edge match set wins over W1C.
      if (wr_stat && wd16[0]) tmr_match <= 1'b0;

      if (tick) begin
        if (tmr_cnt == tmr_cmp) begin
          tmr_match <= 1'b1;
          tmr_cnt   <= tmr_ctrl[1] ? 16'd0 : tmr_cnt + 16'd1;
        end else begin
          tmr_cnt   <= tmr_cnt + 16'd1;
        end
      end
      // Core write takes priority over the tick increment.
      if (wr_cnt) tmr_cnt <= wd16;
    end
  end

  assign gpio_o  = gpio_out;
  assign tmr_irq = tmr_match & tmr_ctrl[2];

endmodule
